// File: rtl/pass_cam_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pass_cam_pkg : shared widths and search-FSM state encoding  rev 1.0     |
// +-----------------------------------------------------------------------+
package pass_cam_pkg;

  localparam int CAM_KEY_W  = 128;
  localparam int CAM_ADDR_W = 4;
  localparam int CAM_DEPTH  = 1 << CAM_ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } cam_state_e;

endpackage : pass_cam_pkg
`default_nettype wire

// File: rtl/pass_cam_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pass_cam_if : controller <-> CAM command/result bundle      rev 1.0     |
// +-----------------------------------------------------------------------+
interface pass_cam_if
  import pass_cam_pkg::*;
#(
  parameter int KEY_W  = CAM_KEY_W,
  parameter int ADDR_W = CAM_ADDR_W
);

  logic              cam_start;
  logic              cam_write_en;
  logic [ADDR_W-1:0] address_in;
  logic [KEY_W-1:0]  key_in;
  logic              match;
  logic [ADDR_W-1:0] match_addr;
  logic              search_done;
  logic              busy;
  logic [ADDR_W-1:0] max_add;
  logic              empty;

  modport master (
    output cam_start,
    output cam_write_en,
    output address_in,
    output key_in,
    input  match,
    input  match_addr,
    input  search_done,
    input  busy,
    input  max_add,
    input  empty
  );

  modport slave (
    input  cam_start,
    input  cam_write_en,
    input  address_in,
    input  key_in,
    output match,
    output match_addr,
    output search_done,
    output busy,
    output max_add,
    output empty
  );

endinterface : pass_cam_if
`default_nettype wire

// File: rtl/pass_cam_store.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pass_cam_store : key registers, valid bits, occupancy tracking rev 1.0  |
// +-----------------------------------------------------------------------+
module pass_cam_store
  import pass_cam_pkg::*;
#(
  parameter int KEY_W  = CAM_KEY_W,
  parameter int ADDR_W = CAM_ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_we,
  input  wire logic [ADDR_W-1:0] i_waddr,
  input  wire logic [KEY_W-1:0]  i_wdata,
  input  wire logic [ADDR_W-1:0] i_raddr,
  output logic      [KEY_W-1:0]  o_rdata,
  output logic                   o_rvalid,
  output logic      [ADDR_W-1:0] o_max_add,
  output logic                   o_empty
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [KEY_W-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_max_add;
  logic              r_empty;

  // Data is left unreset; the valid bits alone decide whether an entry exists.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= '0;
      r_max_add <= '0;
      r_empty   <= 1'b1;
    end else if (i_we) begin
      r_valid[i_waddr] <= 1'b1;
      r_empty          <= 1'b0;
      if (r_empty || (i_waddr > r_max_add)) begin
        r_max_add <= i_waddr;
      end
    end
  end

  assign o_rdata   = r_mem[i_raddr];
  assign o_rvalid  = r_valid[i_raddr];
  assign o_max_add = r_max_add;
  assign o_empty   = r_empty;

endmodule : pass_cam_store
`default_nettype wire

// File: rtl/pass_cam.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pass_cam : sequential-search password CAM (FSM, key, compare) rev 1.0  |
// +-----------------------------------------------------------------------+
module pass_cam
  import pass_cam_pkg::*;
#(
  parameter int KEY_W  = CAM_KEY_W,
  parameter int ADDR_W = CAM_ADDR_W
) (
  input wire logic  clk,
  input wire logic  rst,
  pass_cam_if.slave cam
);

  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_SCAN = 2'(S_SCAN);
  localparam logic [1:0] ST_DONE = 2'(S_DONE);

  logic [1:0]        r_state;
  logic [KEY_W-1:0]  r_key;
  logic [ADDR_W-1:0] r_idx;
  logic              r_match;
  logic [ADDR_W-1:0] r_match_addr;

  logic              w_idle;
  logic              w_wr_accept;
  logic              w_start_accept;
  logic              w_empty_now;
  logic [KEY_W-1:0]  w_rdata;
  logic              w_rvalid;
  logic [ADDR_W-1:0] w_max_add;
  logic              w_empty;
  logic              w_hit;
  logic              w_last;

  assign w_idle         = (r_state == ST_IDLE);
  assign w_wr_accept    = cam.cam_write_en && w_idle;
  assign w_start_accept = cam.cam_start && w_idle;
  // A write landing on the same edge as the start makes the store non-empty.
  assign w_empty_now    = w_empty && !w_wr_accept;

  pass_cam_store #(
    .KEY_W  (KEY_W),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_wr_accept),
    .i_waddr   (cam.address_in),
    .i_wdata   (cam.key_in),
    .i_raddr   (r_idx),
    .o_rdata   (w_rdata),
    .o_rvalid  (w_rvalid),
    .o_max_add (w_max_add),
    .o_empty   (w_empty)
  );

  assign w_hit  = w_rvalid && (w_rdata == r_key);
  assign w_last = (r_idx == w_max_add);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_key        <= '0;
      r_idx        <= '0;
      r_match      <= 1'b0;
      r_match_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_accept) begin
            r_key   <= cam.key_in;
            r_idx   <= '0;
            r_match <= 1'b0;
            if (w_empty_now) begin
              r_match_addr <= '0;
              r_state      <= ST_DONE;
            end else begin
              r_state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (w_hit) begin
            r_match      <= 1'b1;
            r_match_addr <= r_idx;
            r_state      <= ST_DONE;
          end else if (w_last) begin
            r_match      <= 1'b0;
            r_match_addr <= '0;
            r_state      <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cam.match       = r_match;
  assign cam.match_addr  = r_match_addr;
  assign cam.search_done = (r_state == ST_DONE);
  assign cam.busy        = (r_state == ST_SCAN);
  assign cam.max_add     = w_max_add;
  assign cam.empty       = w_empty;

endmodule : pass_cam
`default_nettype wire

// File: tb/tb_pass_cam.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pass_cam : directed stimulus with a latency/result model  rev 1.0    |
// +-----------------------------------------------------------------------+
module tb_pass_cam;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pass_cam_if #(.KEY_W(128), .ADDR_W(4)) cam_if ();

  pass_cam #(.KEY_W(128), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .cam (cam_if.slave)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: storage as arrays, search outcome computed from the lookup rules
  // and turned into an absolute completion cycle.
  logic [127:0] m_mem [16];
  bit           m_valid [16];
  bit           m_empty = 1'b1;
  int           m_max = 0;
  bit           m_active = 1'b0;
  int           m_done_cyc = 0;
  bit           m_match = 1'b0;
  int           m_addr = 0;
  bit           p_match = 1'b0;
  int           p_addr = 0;
  int           cyc = 0;

  always @(posedge clk) begin
    int  prev;
    int  lat;
    int  hi;
    bit  hit;
    bit  idle;
    prev = cyc;
    cyc  = cyc + 1;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_empty = 1'b1; m_max = 0; m_active = 1'b0;
      m_match = 1'b0; m_addr = 0;
    end else begin
      idle = !m_active;
      if (m_active && prev == m_done_cyc) m_active = 1'b0;
      if (idle && cam_if.cam_write_en) begin
        m_mem[cam_if.address_in]   = cam_if.key_in;
        m_valid[cam_if.address_in] = 1'b1;
        if (m_empty || int'(cam_if.address_in) > m_max) m_max = int'(cam_if.address_in);
        m_empty = 1'b0;
      end
      if (idle && cam_if.cam_start) begin
        m_match = 1'b0;
        if (m_empty) begin
          lat = 1; p_match = 1'b0; p_addr = 0;
        end else begin
          hit = 1'b0; hi = 0;
          for (int i = 0; i <= m_max; i++)
            if (!hit && m_valid[i] && m_mem[i] == cam_if.key_in) begin hit = 1'b1; hi = i; end
          p_match = hit;
          p_addr  = hit ? hi : 0;
          lat     = hit ? 2 + hi : 2 + m_max;
        end
        m_active   = 1'b1;
        m_done_cyc = cyc + lat - 1;
      end
      if (m_active && cyc == m_done_cyc) begin
        m_match = p_match;
        m_addr  = p_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",        cam_if.busy,        128'(m_active && cyc < m_done_cyc));
      chk("search_done", cam_if.search_done, 128'(m_active && cyc == m_done_cyc));
      chk("match",       cam_if.match,       128'(m_match));
      chk("match_addr",  cam_if.match_addr,  128'(m_addr));
      chk("empty",       cam_if.empty,       128'(m_empty));
      chk("max_add",     cam_if.max_add,     128'(m_max));
    end
  end

  task automatic do_write(input logic [3:0] a, input logic [127:0] k);
    @(negedge clk);
    cam_if.cam_write_en = 1'b1; cam_if.address_in = a; cam_if.key_in = k;
    @(negedge clk);
    cam_if.cam_write_en = 1'b0;
  endtask

  // exp_lat is k in "search_done at T+k"; a write on the start cycle is optional.
  task automatic do_search(input string name, input logic [127:0] k, input int exp_lat,
                           input bit exp_m, input logic [3:0] exp_a,
                           input bit wr, input logic [3:0] wa);
    int  t0;
    bit  got;
    @(negedge clk);
    cam_if.cam_start = 1'b1; cam_if.key_in = k;
    cam_if.cam_write_en = wr; cam_if.address_in = wa;
    t0 = cyc + 1;
    @(negedge clk);
    cam_if.cam_start = 1'b0; cam_if.cam_write_en = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (cam_if.search_done) begin
        got = 1'b1;
        chk({name, "_latency"}, 128'(cyc - t0 + 1), 128'(exp_lat));
        chk({name, "_match"},   cam_if.match,      128'(exp_m));
        chk({name, "_addr"},    cam_if.match_addr, 128'(exp_a));
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk({name, "_timeout"}, 128'(0), 128'(1));
  endtask

  localparam logic [127:0] KA5 = {16{8'hA5}};
  localparam logic [127:0] K0  = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] K1  = 128'h1010_2020_3030_4040_5050_6060_7070_8080;
  localparam logic [127:0] K2  = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
  localparam logic [127:0] KS  = 128'h5A5A_0000_FFFF_1234_ABCD_9876_0F0F_F0F0;
  localparam logic [127:0] KX  = 128'hFEED_FACE_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] KN  = 128'h0BAD_C0DE_0BAD_C0DE_0BAD_C0DE_0BAD_C0DE;
  localparam logic [127:0] K9  = 128'h9999_9999_9999_9999_9999_9999_9999_9999;

  initial begin
    int seen;
    cam_if.cam_start = 1'b0; cam_if.cam_write_en = 1'b0;
    cam_if.address_in = '0;  cam_if.key_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    chk("rst_empty",       cam_if.empty,       128'(1));
    chk("rst_max_add",     cam_if.max_add,     128'(0));
    chk("rst_match",       cam_if.match,       128'(0));
    chk("rst_match_addr",  cam_if.match_addr,  128'(0));
    chk("rst_search_done", cam_if.search_done, 128'(0));
    chk("rst_busy",        cam_if.busy,        128'(0));

    do_search("empty_search", KA5, 1, 1'b0, 4'd0, 1'b0, 4'd0);

    do_write(4'd0, K0);
    do_write(4'd1, K1);
    do_write(4'd2, K2);
    chk("max_add_2", cam_if.max_add, 128'(2));
    do_search("hit_k2", K2, 4, 1'b1, 4'd2, 1'b0, 4'd0);

    do_write(4'd3, KS);
    do_write(4'd7, KS);
    chk("max_add_7", cam_if.max_add, 128'(7));
    do_search("lowest_dup", KS, 5, 1'b1, 4'd3, 1'b0, 4'd0);
    do_search("miss_hole",  KX, 9, 1'b0, 4'd0, 1'b0, 4'd0);

    do_search("same_cycle_wr", KN, 2, 1'b1, 4'd0, 1'b1, 4'd0);

    // Writes issued while the scan is running must be dropped.
    @(negedge clk);
    cam_if.cam_start = 1'b1; cam_if.key_in = KX;
    @(negedge clk);
    cam_if.cam_start = 1'b0;
    cam_if.cam_write_en = 1'b1; cam_if.address_in = 4'd9; cam_if.key_in = K9;
    @(negedge clk);
    cam_if.address_in = 4'd1;
    @(negedge clk);
    cam_if.cam_write_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_wr_max_add", cam_if.max_add, 128'(7));
    do_search("busy_wr_k1", K1, 3, 1'b1, 4'd1, 1'b0, 4'd0);
    do_search("busy_wr_k9", K9, 9, 1'b0, 4'd0, 1'b0, 4'd0);

    // Reset in the middle of a scan.
    @(negedge clk);
    cam_if.cam_start = 1'b1; cam_if.key_in = KX;
    @(negedge clk);
    cam_if.cam_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      if (cam_if.search_done) seen++;
      @(negedge clk);
    end
    chk("rst_mid_no_done", 128'(seen), 128'(0));
    chk("rst_mid_empty",   cam_if.empty, 128'(1));
    do_search("after_rst", K1, 1, 1'b0, 4'd0, 1'b0, 4'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_pass_cam
`default_nettype wire
